// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: definitions shared by the serial frame transmitter and its
// companion receiver (FSM state type, frame width, line levels).
package frame_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_GAP   = 2'd3
   } frame_state_t;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic START_LEVEL     = 1'b1;
   localparam logic IDLE_LEVEL      = 1'b0;

endpackage

// File: rtl/frame_tx_fifo.sv
// frame_tx_fifo: synchronous byte FIFO with push/pop, full/empty and an
// occupancy count. Pushes while full and pops while empty are ignored.
// There is no bypass path: a pushed entry is visible only after the edge.
module frame_tx_fifo
   import frame_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [FRAME_DATA_BITS-1:0] push_data,
   input  logic                       pop,
   output logic [FRAME_DATA_BITS-1:0] pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [FRAME_DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic                       do_push;
   logic                       do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage, pointers (wrap naturally modulo DEPTH) and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/frame_transmitter.sv
// frame_transmitter: buffers bytes from a valid/ready producer and
// serialises each as: start bit 1, d[0]..d[7] LSB first, then GAP_CYCLES
// zeros. The line idles at 0 and only ever goes high for start/data bits.
// Build option FRAME_TX_FIFO_EN: when defined the buffer is a DEPTH-entry
// FIFO; otherwise it is a single holding register and DEPTH is ignored.
//
// state | meaning
// IDLE  | line low, waiting for a buffered byte to pop
// START | driving the start bit next edge
// DATA  | driving data bits, LSB first
// GAP   | driving the low guard gap; last cycle may pop the next byte
module frame_transmitter
   import frame_tx_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [FRAME_DATA_BITS-1:0] in_data,
   output logic                       in_ready,
   output logic                       txd,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(FRAME_DATA_BITS);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   frame_state_t               state;
   logic [FRAME_DATA_BITS-1:0] shift_reg;
   logic [BW-1:0]              bit_cnt;
   logic [GW-1:0]              gap_cnt;
   logic                       push;
   logic                       pop;
   logic                       buf_empty;
   logic [FRAME_DATA_BITS-1:0] head;

   assign push = in_valid && in_ready;

`ifdef FRAME_TX_FIFO_EN
   logic fifo_full;

   frame_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (buf_empty),
      .count     (count)
   );

   assign in_ready = !fifo_full;
`else
   logic                       hold_full;
   logic [FRAME_DATA_BITS-1:0] hold_data;

   // Single holding register: filled by a push, emptied by a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (push) begin
         hold_full <= 1'b1;
         hold_data <= in_data;
      end else if (pop) begin
         hold_full <= 1'b0;
      end
   end

   assign head      = hold_data;
   assign buf_empty = !hold_full;
   assign in_ready  = !hold_full;
   assign count     = {{(CW-1){1'b0}}, hold_full};
`endif

   // A byte leaves the buffer from IDLE or on the final guard cycle.
   assign pop  = !buf_empty &&
                 ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == '0)));
   assign busy = (state != ST_IDLE) || (count != '0);

   // Frame sequencer with registered line output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         txd       <= IDLE_LEVEL;
         shift_reg <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               txd <= IDLE_LEVEL;
               if (pop) begin
                  shift_reg <= head;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               txd     <= START_LEVEL;
               bit_cnt <= BW'(FRAME_DATA_BITS - 1);
               state   <= ST_DATA;
            end
            ST_DATA: begin
               txd       <= shift_reg[0];
               shift_reg <= {1'b0, shift_reg[FRAME_DATA_BITS-1:1]};
               if (bit_cnt == '0) begin
                  gap_cnt <= GW'(GAP_CYCLES - 1);
                  state   <= ST_GAP;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_GAP: begin
               txd <= IDLE_LEVEL;
               if (gap_cnt == '0) begin
                  if (pop) begin
                     shift_reg <= head;
                     state     <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/frame_transmitter.md
# frame_transmitter

Serial frame transmitter that feeds the team's one-bit-per-clock serial receiver. It accepts bytes over a valid/ready handshake, buffers them, and serialises each byte onto a single line `txd`. Each frame is a high start bit, then 8 data bits LSB first at one bit per clock, then a low guard gap. It sits directly upstream of the serial receiver, driving its `rxd` input.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, default 1: low guard cycles after bit 7; ≥1. A value of 1 is the minimum the receiver tolerates.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: producer offers `in_data`.
- `in_data`  in  8: byte to send.
- `in_ready`  out  1: block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `txd`  out  1: serial line, registered; idle level 0.
- `busy`  out  1: high when a frame is in progress or the buffer is non-empty.
- `count`  out  $clog2(DEPTH)+1: bytes buffered, excluding the byte being shifted.

## Operation
- Line protocol:
  - Idle level is 0.
  - Frame = start bit 1, then d[0]..d[7], then `GAP_CYCLES` zeros.
  - Any 1 on an idle line starts a frame at the receiver, so `txd` must never be 1 outside a start or data bit.
- FSM states and transitions:
  - IDLE: `txd` is 0. If the buffer is non-empty, pop into a shift register and go to START.
  - START: `txd`=1 for one cycle, then go to DATA.
  - DATA: `txd`=shift[0], shift right, 3-bit bit counter; after bit 7 go to GAP.
  - GAP: `txd`=0 for `GAP_CYCLES` cycles.
  - GAP exit: on the last GAP cycle, if the buffer is non-empty, pop and go straight to START; otherwise go to IDLE.
- Buffer:
  - `in_ready` = !full, derived combinationally from `count`.
  - A push while full is impossible; no bypass on full, even with a same-cycle pop.
  - A push into an empty buffer becomes poppable on the next cycle; there is no empty bypass.
  - Simultaneous push and pop leaves `count` unchanged.
- `busy` = (state != IDLE) || (`count` != 0).
- Pointer wrap-around is natural modulo DEPTH. Byte order is strictly FIFO.

## Timing
- Reset values: `txd`=0, `in_ready`=1, `busy`=0, `count`=0, state IDLE, buffer and pointers cleared.
- Reset mid-frame:
  - The frame is aborted and `txd`=0 from the next edge.
  - Buffered bytes are discarded.
  - The receiver may latch a corrupt byte; this is accepted behaviour.
- Latency: a byte accepted at edge E0 into an empty, idle block is popped at E1. The start bit is on `txd` from E2 to E3, and d[0] is on `txd` from E3 to E4.
- Throughput: back-to-back frames start every 9+`GAP_CYCLES` cycles, which is 10 by default.
- `count` and `in_ready` update on the edge following a push or pop.

## Configuration
- `FRAME_TX_FIFO_EN` defined:
  - The buffer is a DEPTH-entry FIFO as described above.
- `FRAME_TX_FIFO_EN` undefined:
  - The buffer is a single holding register and `DEPTH` is ignored.
  - `in_ready` = holding register empty; `count` is 0 or 1.
  - FSM, line timing and latency are unchanged.

## Structure
- Shared package `frame_tx_pkg`:
  - FSM state typedef (IDLE, START, DATA, GAP).
  - `FRAME_DATA_BITS`=8.
  - `START_LEVEL`=1 and `IDLE_LEVEL`=0.
  - Reused by the receiver.
- Sub-module `frame_tx_fifo` (synchronous FIFO with push, pop, full, empty, count). It is instantiated only under `FRAME_TX_FIFO_EN`.

## Test plan
- Single byte 0xA5 after reset: `txd` from E2 is 1, 1,0,1,0,0,1,0,1, then 0, then idle 0; `busy` falls after the gap.
- Byte 0x00: `txd` is 1 for exactly one cycle, then 9 zeros; no spurious second start bit.
- Push 0x01, 0x80, 0xFF, 0x3C on consecutive cycles, DEPTH=4: start bits 10 cycles apart, bytes in order, `count` peaks at 3.
- Push 8 bytes continuously with `in_valid` held, DEPTH=4: `in_ready` deasserts at `count`==4 and reasserts after each pop; all 8 bytes are transmitted in order with none lost or duplicated.
- Assert `rst` during DATA bit 4 with 2 bytes buffered: `txd`=0, `count`=0 and `busy`=0 after the edge; nothing further is sent.
- Loopback into the serial receiver, 200 random bytes with random `in_valid` gaps: the receiver's `recive` pulses exactly 200 times with matching `data`. Run with and without `FRAME_TX_FIFO_EN`.
